// File: rtl/autocorr_window.sv
// Windowed complex lag autocorrelation: sum over the last 2^WINDOW_SHIFT
// products x[n]*conj(x[n-D]), fed by the RAM sample delay line.
module autocorr_window #(
   parameter  int DATA_WIDTH   = 16,
   parameter  int WINDOW_SHIFT = 4,
   localparam int PROD_WIDTH   = 2*DATA_WIDTH+1,
   localparam int SUM_WIDTH    = PROD_WIDTH+WINDOW_SHIFT
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [2*DATA_WIDTH-1:0] sample_in,
   input  logic [2*DATA_WIDTH-1:0] sample_delayed,
   input  logic                    input_strobe,
   output logic [SUM_WIDTH-1:0]    corr_i,
   output logic [SUM_WIDTH-1:0]    corr_q,
   output logic                    window_full,
   output logic                    output_strobe
);

   localparam int XW = 2*DATA_WIDTH;
   localparam int W  = 1 << WINDOW_SHIFT;
   localparam logic [WINDOW_SHIFT-1:0] LAST_FILL = {WINDOW_SHIFT{1'b1}};

   typedef enum logic {FILL, RUN} state_t;

   // Components sign-extended to product width so the multiply is exact.
   logic signed [XW-1:0] xi, xq, di, dq;

   assign xi = {{DATA_WIDTH{sample_in[XW-1]}},              sample_in[XW-1:DATA_WIDTH]};
   assign xq = {{DATA_WIDTH{sample_in[DATA_WIDTH-1]}},      sample_in[DATA_WIDTH-1:0]};
   assign di = {{DATA_WIDTH{sample_delayed[XW-1]}},         sample_delayed[XW-1:DATA_WIDTH]};
   assign dq = {{DATA_WIDTH{sample_delayed[DATA_WIDTH-1]}}, sample_delayed[DATA_WIDTH-1:0]};

   // ---------------- S1: partial products ----------------
   logic                 s1_valid;
   logic signed [XW-1:0] pp_ii, pp_qq, pp_qi, pp_iq;

   // NOTE: sequential state is always assigned with <=, so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         pp_ii    <= '0;
         pp_qq    <= '0;
         pp_qi    <= '0;
         pp_iq    <= '0;
      end else if (!enable) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= input_strobe;
         if (input_strobe) begin
            pp_ii <= xi * di;
            pp_qq <= xq * dq;
            pp_qi <= xq * di;
            pp_iq <= xi * dq;
         end
      end
   end

   // ---------------- S2: lag product, window store ----------------
   logic [PROD_WIDTH-1:0]   p_i_c, p_q_c;
   logic                    s2_valid;
   logic [PROD_WIDTH-1:0]   s2_p_i, s2_p_q;
   logic [PROD_WIDTH-1:0]   s2_old_i, s2_old_q;
   logic [WINDOW_SHIFT-1:0] wptr;
   logic [2*PROD_WIDTH-1:0] store [W];

   assign p_i_c = {pp_ii[XW-1], pp_ii} + {pp_qq[XW-1], pp_qq};
   assign p_q_c = {pp_qi[XW-1], pp_qi} - {pp_iq[XW-1], pp_iq};

   // NOTE: the window store has no reset; stale entries are masked while
   // filling, so clearing it would only cost a reset fan-out for nothing.
   always_ff @(posedge clock) begin
      if (enable && s1_valid)
         store[wptr] <= {p_i_c, p_q_c};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         s2_p_i   <= '0;
         s2_p_q   <= '0;
         s2_old_i <= '0;
         s2_old_q <= '0;
         wptr     <= '0;
      end else if (!enable) begin
         s2_valid <= 1'b0;
         wptr     <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_p_i <= p_i_c;
            s2_p_q <= p_q_c;
            // Read-before-write: this is the product leaving the window.
            {s2_old_i, s2_old_q} <= store[wptr];
            wptr <= wptr + WINDOW_SHIFT'(1);
         end
      end
   end

   // ---------------- S3: accumulate, fill tracking ----------------
   state_t                  state;
   logic [WINDOW_SHIFT-1:0] fill_cnt;
   logic [SUM_WIDTH-1:0]    sum_i, sum_q;
   logic [PROD_WIDTH-1:0]   old_i, old_q;
   logic [SUM_WIDTH-1:0]    sum_i_nxt, sum_q_nxt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      old_i = '0;
      old_q = '0;
      if (state == RUN) begin
         old_i = s2_old_i;
         old_q = s2_old_q;
      end
      sum_i_nxt = sum_i + {{WINDOW_SHIFT{s2_p_i[PROD_WIDTH-1]}}, s2_p_i}
                        - {{WINDOW_SHIFT{old_i[PROD_WIDTH-1]}},  old_i};
      sum_q_nxt = sum_q + {{WINDOW_SHIFT{s2_p_q[PROD_WIDTH-1]}}, s2_p_q}
                        - {{WINDOW_SHIFT{old_q[PROD_WIDTH-1]}},  old_q};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= FILL;
         fill_cnt      <= '0;
         sum_i         <= '0;
         sum_q         <= '0;
         window_full   <= 1'b0;
         output_strobe <= 1'b0;
      end else if (!enable) begin
         state         <= FILL;
         fill_cnt      <= '0;
         sum_i         <= '0;
         sum_q         <= '0;
         window_full   <= 1'b0;
         output_strobe <= 1'b0;
      end else begin
         output_strobe <= s2_valid;
         if (s2_valid) begin
            sum_i <= sum_i_nxt;
            sum_q <= sum_q_nxt;
            if (state == FILL) begin
               fill_cnt <= fill_cnt + WINDOW_SHIFT'(1);
               if (fill_cnt == LAST_FILL) begin
                  state       <= RUN;
                  window_full <= 1'b1;
               end
            end
         end
      end
   end

   assign corr_i = sum_i;
   assign corr_q = sum_q;

endmodule

// File: tb/tb_autocorr_window.sv
// Directed bench for autocorr_window: a brute-force window-sum model delayed
// by the 3-stage latency, plus hand-computed spot values.
module tb_autocorr_window;

   localparam int DW = 16;
   localparam int SW = 2*DW+1+4;
   localparam int WN = 16;

   logic             clock;
   logic             reset_n;
   logic             enable;
   logic [2*DW-1:0]  sample_in;
   logic [2*DW-1:0]  sample_delayed;
   logic             input_strobe;
   logic [SW-1:0]    corr_i;
   logic [SW-1:0]    corr_q;
   logic             window_full;
   logic             output_strobe;

   autocorr_window #(.DATA_WIDTH(DW), .WINDOW_SHIFT(4)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .enable         (enable),
      .sample_in      (sample_in),
      .sample_delayed (sample_delayed),
      .input_strobe   (input_strobe),
      .corr_i         (corr_i),
      .corr_q         (corr_q),
      .window_full    (window_full),
      .output_strobe  (output_strobe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic   v;
      longint si;
      longint sq;
      logic   full;
   } ent_t;

   localparam ent_t ZERO = '{v: 1'b0, si: 0, sq: 0, full: 1'b0};

   int     checks = 0;
   int     errors = 0;
   longint hist_i[$];
   longint hist_q[$];
   int     fill;
   ent_t   pipe[3];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] to_sw(input longint v);
      logic [SW-1:0] t;
      t = SW'(v);
      return {{(64-SW){1'b0}}, t};
   endfunction

   task automatic model_flush();
      hist_i.delete();
      hist_q.delete();
      fill = 0;
      for (int k = 0; k < 3; k++) pipe[k] = ZERO;
   endtask

   // One clock cycle: drive inputs, advance model, step, compare all outputs.
   task automatic cyc(input string tag, input bit en, input bit stb,
                      input int xi, input int xq, input int di, input int dq);
      ent_t   n;
      longint pi, pq;
      n = ZERO;
      if (!en) begin
         model_flush();
      end else begin
         if (stb) begin
            pi = longint'(xi) * di + longint'(xq) * dq;
            pq = longint'(xq) * di - longint'(xi) * dq;
            hist_i.push_back(pi);
            hist_q.push_back(pq);
            if (hist_i.size() > WN) begin
               void'(hist_i.pop_front());
               void'(hist_q.pop_front());
            end
            fill++;
         end
         n.v = stb;
         foreach (hist_i[k]) n.si += hist_i[k];
         foreach (hist_q[k]) n.sq += hist_q[k];
         n.full = (fill >= WN);
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = n;
      end
      enable         = en;
      input_strobe   = stb;
      sample_in      = {16'(xi), 16'(xq)};
      sample_delayed = {16'(di), 16'(dq)};
      @(posedge clock);
      #1;
      check({tag, "_strobe"}, 64'(output_strobe), 64'(pipe[2].v));
      check({tag, "_corr_i"}, 64'(corr_i), to_sw(pipe[2].si));
      check({tag, "_corr_q"}, 64'(corr_q), to_sw(pipe[2].sq));
      check({tag, "_full"},   64'(window_full), 64'(pipe[2].full));
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cyc(tag, 1'b1, 1'b0, 0, 0, 0, 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      enable         = 1'b1;
      input_strobe   = 1'b0;
      sample_in      = '0;
      sample_delayed = '0;
      model_flush();

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_strobe", 64'(output_strobe), 64'd0);
      check("rst_corr_i", 64'(corr_i), 64'd0);
      check("rst_corr_q", 64'(corr_q), 64'd0);
      check("rst_full",   64'(window_full), 64'd0);
      reset_n = 1'b1;

      // Ramp: x=d=(1000,0), corr_i climbs 1e6 per strobe to 16e6
      for (int k = 0; k < 20; k++) cyc("ramp", 1'b1, 1'b1, 1000, 0, 1000, 0);
      idle("ramp_drain", 3);
      check("ramp_final_i", 64'(corr_i), 64'd16000000);
      check("ramp_final_q", 64'(corr_q), 64'd0);
      check("ramp_full",    64'(window_full), 64'd1);

      // Quadrature: x=(0,1000), d=(1000,0) -> p=(0,1e6)
      for (int k = 0; k < 20; k++) cyc("quad", 1'b1, 1'b1, 0, 1000, 1000, 0);
      idle("quad_drain", 3);
      check("quad_final_i", 64'(corr_i), 64'd0);
      check("quad_final_q", 64'(corr_q), 64'd16000000);

      // Sparse strobes every 3rd cycle, x=d=(100,100) -> p=(20000,0)
      for (int k = 0; k < 40; k++) begin
         cyc("sparse", 1'b1, 1'b1, 100, 100, 100, 100);
         idle("sparse_gap", 2);
      end
      idle("sparse_drain", 3);
      check("sparse_final_i", 64'(corr_i), 64'd320000);
      check("sparse_final_q", 64'(corr_q), 64'd0);

      // Extreme inputs: p_i = 2^31 each, window sum 2^35
      for (int k = 0; k < 16; k++) cyc("ext", 1'b1, 1'b1, -32768, -32768, -32768, -32768);
      idle("ext_drain", 3);
      check("ext_final_i", 64'(corr_i), 64'h8_0000_0000);
      check("ext_final_q", 64'(corr_q), 64'd0);
      check("ext_full",    64'(window_full), 64'd1);

      // Window slide: constant (1000,0) products, then zero inputs drain it
      for (int k = 0; k < 16; k++) cyc("slide_load", 1'b1, 1'b1, 1000, 0, 1000, 0);
      idle("slide_load_drain", 3);
      check("slide_peak_i", 64'(corr_i), 64'd16000000);
      for (int k = 0; k < 8; k++) cyc("slide", 1'b1, 1'b1, 0, 0, 0, 0);
      idle("slide_mid_drain", 3);
      check("slide_mid_i", 64'(corr_i), 64'd8000000);
      for (int k = 0; k < 8; k++) cyc("slide", 1'b1, 1'b1, 0, 0, 0, 0);
      idle("slide_drain", 3);
      check("slide_end_i", 64'(corr_i), 64'd0);

      // Enable dropped for one cycle at strobe 10 (strobe discarded)
      for (int k = 0; k < 9; k++) cyc("flush_pre", 1'b1, 1'b1, 1000, 0, 1000, 0);
      cyc("flush", 1'b0, 1'b1, 1000, 0, 1000, 0);
      check("flush_corr_i", 64'(corr_i), 64'd0);
      check("flush_full",   64'(window_full), 64'd0);
      check("flush_strobe", 64'(output_strobe), 64'd0);
      for (int k = 0; k < 20; k++) cyc("refill", 1'b1, 1'b1, 1000, 0, 1000, 0);
      idle("refill_drain", 3);
      check("refill_final_i", 64'(corr_i), 64'd16000000);

      // Asynchronous reset mid-cycle: outputs clear before the next edge
      for (int k = 0; k < 5; k++) cyc("areset_pre", 1'b1, 1'b1, 0, 1000, 1000, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_strobe", 64'(output_strobe), 64'd0);
      check("areset_corr_i", 64'(corr_i), 64'd0);
      check("areset_corr_q", 64'(corr_q), 64'd0);
      check("areset_full",   64'(window_full), 64'd0);
      model_flush();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 18; k++) cyc("post_reset", 1'b1, 1'b1, 1000, 0, 1000, 0);
      idle("post_reset_drain", 3);
      check("post_reset_i",    64'(corr_i), 64'd16000000);
      check("post_reset_full", 64'(window_full), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
